// File: rtl/full_adder_pkg.sv
// Shared constants and the result record for the registered ripple-carry adder.
// The record's sum field is sized for the widest legal adder; narrower instances use the low bits.
package full_adder_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam int MAX_WIDTH     = 64;

    typedef struct packed {
        logic                 cout;
        logic                 overflow;
        logic [MAX_WIDTH-1:0] sum;
    } result_t;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder cell, purely combinational.
// Zero latency; there is no flow control.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic prop;

    assign prop = a ^ b;
    assign sum  = prop ^ cin;
    assign cout = (a & b) | (cin & prop);

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with registered sum, carry-out and signed overflow.
// One-cycle latency, one result per cycle, never backpressures; outputs hold when in_valid is low.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             out_valid
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_bits;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum_bits[i]),
            .cout (carry[i+1])
        );
    end

    result_t res_d, res_q;
    logic    vld_d, vld_q;

    // The hold path feeds back res_q, so inputs are ignored entirely while in_valid is low.
    always_comb begin
        res_d = res_q;
        vld_d = 1'b0;
        if (in_valid) begin
            res_d                = '0;
            res_d.sum[WIDTH-1:0] = sum_bits;
            res_d.cout           = carry[WIDTH];
            res_d.overflow       = carry[WIDTH] ^ carry[WIDTH-1];
            vld_d                = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
            vld_q <= 1'b0;
        end else begin
            res_q <= res_d;
            vld_q <= vld_d;
        end
    end

    assign sum       = res_q.sum[WIDTH-1:0];
    assign cout      = res_q.cout;
    assign overflow  = res_q.overflow;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder at WIDTH=1 and WIDTH=4 with directed vectors.
module tb_full_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       v1, a1, b1, c1, s1, co1, ov1, ov1_vld;
    logic       v4, c4, co4, ov4, ov4_vld;
    logic [3:0] a4, b4, s4;

    full_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
        .sum(s1), .cout(co1), .overflow(ov1), .out_valid(ov1_vld)
    );

    full_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .cin(c4),
        .sum(s4), .cout(co4), .overflow(ov4), .out_valid(ov4_vld)
    );

    int checks = 0;
    int errors = 0;

    // Expected words are {cout, overflow, sum}.
    logic [2:0] q1[$];
    logic [5:0] q4[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents a result.
    always @(posedge clk) begin
        #1;
        if (ov1_vld === 1'b1) begin
            if (q1.size() == 0) check("w1_unexpected_valid", 64'(ov1_vld), 64'd0);
            else check("w1_result", 64'({co1, ov1, s1}), 64'(q1.pop_front()));
        end
        if (ov4_vld === 1'b1) begin
            if (q4.size() == 0) check("w4_unexpected_valid", 64'(ov4_vld), 64'd0);
            else check("w4_result", 64'({co4, ov4, s4}), 64'(q4.pop_front()));
        end
    end

    // {a, b, cin, cout, sum, overflow}; overflow = cin ^ cout at WIDTH=1.
    logic [5:0] tab1 [8] = '{
        6'b000_000, 6'b001_011, 6'b010_010, 6'b011_100,
        6'b100_010, 6'b101_100, 6'b110_101, 6'b111_110
    };

    // {a, b, cin, sum, cout, overflow}
    logic [14:0] tab4 [5] = '{
        {4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0},
        {4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1},
        {4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0},
        {4'h3, 4'h4, 1'b1, 4'h8, 1'b0, 1'b1},
        {4'h5, 4'hA, 1'b0, 4'hF, 1'b0, 1'b0}
    };

    task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic c,
                          input logic [3:0] s, input logic co, input logic ov);
        @(negedge clk);
        v4 = 1'b1; a4 = a; b4 = b; c4 = c;
        q4.push_back({co, ov, s});
    endtask

    initial begin
        rst = 1'b1;
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        v4 = 1'b0; a4 = 4'h0; b4 = 4'h0; c4 = 1'b0;
        #1;
        check("reset_w1", 64'({ov1_vld, co1, ov1, s1}), 64'd0);
        check("reset_w4", 64'({ov4_vld, co4, ov4, s4}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // All eight single-bit combinations, back to back.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            v1 = 1'b1;
            {a1, b1, c1} = tab1[i][5:3];
            q1.push_back({tab1[i][2], tab1[i][0], tab1[i][1]});
        end
        @(negedge clk);
        v1 = 1'b0;

        for (int i = 0; i < 5; i++)
            drive4(tab4[i][14:11], tab4[i][10:7], tab4[i][6], tab4[i][5:2], tab4[i][1], tab4[i][0]);

        // Hold: a capture followed by an idle cycle with changing and unknown operands.
        drive4(4'h2, 4'h3, 1'b0, 4'h5, 1'b0, 1'b0);
        @(negedge clk);
        v4 = 1'b0; a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
        @(posedge clk); #1;
        check("hold_valid_low", 64'(ov4_vld), 64'd0);
        check("hold_outputs", 64'({co4, ov4, s4}), 64'({1'b0, 1'b0, 4'h5}));
        @(negedge clk);
        a4 = 'x; b4 = 'x; c4 = 'x;
        @(posedge clk); #1;
        check("hold_with_x", 64'({ov4_vld, co4, ov4, s4}), 64'({1'b0, 1'b0, 1'b0, 4'h5}));

        // Asynchronous reset between edges right after a capture.
        drive4(4'h1, 4'h1, 1'b0, 4'h2, 1'b0, 1'b0);
        @(negedge clk);
        v4 = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("async_rst_w4", 64'({ov4_vld, co4, ov4, s4}), 64'd0);
        check("async_rst_w1", 64'({ov1_vld, co1, ov1, s1}), 64'd0);
        @(posedge clk); #1;
        check("rst_held_w4", 64'({ov4_vld, co4, ov4, s4}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_idle", 64'({ov4_vld, s4}), 64'd0);

        // Capture resumes on the first edge after reset.
        drive4(4'h6, 4'h6, 1'b1, 4'hD, 1'b0, 1'b1);
        @(negedge clk);
        v4 = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        check("w1_scoreboard_drained", 64'(q1.size()), 64'd0);
        check("w4_scoreboard_drained", 64'(q4.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no end of stimulus, expected finish before 20000");
        $fatal(1);
    end

endmodule
